// File: rtl/ls_ex_queue_pkg.sv
// Shared defines for the load/store execution queue.
// Opcodes, mc flags, bus widths and decode helpers.
package ls_ex_queue_pkg;

    localparam int ADDR_LEN   = 32;
    localparam int DATA_LEN   = 32;
    localparam int OPENUM_LEN = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic FLAG_READ  = 1'b0;
    localparam logic FLAG_WRITE = 1'b1;

    typedef enum logic [OPENUM_LEN-1:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LH  = 4'd2,
        LW  = 4'd3,
        LBU = 4'd4,
        LHU = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        SW  = 4'd8
    } openum_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef struct packed {
        openum_t             op;
        logic [ADDR_LEN-1:0] addr;
        logic [DATA_LEN-1:0] data;
    } req_t;

    function automatic logic is_store(openum_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic [2:0] mem_size(openum_t op);
        unique case (op)
            LB, LBU, SB: return 3'd1;
            LH, LHU, SH: return 3'd2;
            LW, SW:      return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic logic [DATA_LEN-1:0] load_ext(
        openum_t             op,
        logic [DATA_LEN-1:0] d
    );
        unique case (op)
            LB:      return {{(DATA_LEN-8){d[7]}}, d[7:0]};
            LH:      return {{(DATA_LEN-16){d[15]}}, d[15:0]};
            LBU:     return {{(DATA_LEN-8){1'b0}}, d[7:0]};
            LHU:     return {{(DATA_LEN-16){1'b0}}, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/ls_ex_queue_if.sv
// Memory-controller port of the load/store queue.
// master = queue side, slave = controller side.
interface ls_ex_queue_if;
    import ls_ex_queue_pkg::*;

    logic                ena_to_mc;
    logic [ADDR_LEN-1:0] addr_to_mc;
    logic [DATA_LEN-1:0] data_to_mc;
    logic                wr_flag_to_mc;
    logic [2:0]          size_to_mc;
    logic                ok_flag_from_mc;
    logic [DATA_LEN-1:0] data_from_mc;

    modport master (
        output ena_to_mc,
        output addr_to_mc,
        output data_to_mc,
        output wr_flag_to_mc,
        output size_to_mc,
        input  ok_flag_from_mc,
        input  data_from_mc
    );

    modport slave (
        input  ena_to_mc,
        input  addr_to_mc,
        input  data_to_mc,
        input  wr_flag_to_mc,
        input  size_to_mc,
        output ok_flag_from_mc,
        output data_from_mc
    );

endinterface

// File: rtl/ls_req_fifo.sv
// Circular request FIFO; DEPTH must be a power of two.
// Combinational head read, synchronous clear.
module ls_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

endmodule

// File: rtl/ls_ex_queue.sv
// Load/store execution queue: buffers LSB requests, issues them
// one at a time to the memory controller, broadcasts loads on CDB.
module ls_ex_queue
    import ls_ex_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [OPENUM_LEN-1:0] openum,
    input  logic [ADDR_LEN-1:0]   mem_addr,
    input  logic [DATA_LEN-1:0]   store_value,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  flush,
    output logic                  ready_to_lsb,
    ls_ex_queue_if.master         mc,
    output logic                  valid,
    output logic [DATA_LEN-1:0]   result,
    output logic [TAG_W-1:0]      tag_out
);

    localparam int EW = $bits(req_t) + TAG_W;

    state_t              state;
    state_t              state_n;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic [EW-1:0]       din;
    logic [EW-1:0]       dout;
    req_t                head_req;
    logic [TAG_W-1:0]    head_tag;
    logic                squash;
    openum_t             op_q;
    logic [TAG_W-1:0]    tag_q;
    logic                ena_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] data_q;
    logic                wr_q;
    logic [2:0]          size_q;

    assign ready_to_lsb = !full;
    assign push = ena && (openum != NOP) && !full && !flush;
    assign din  = {openum, mem_addr, store_value, tag_in};
    assign {head_req, head_tag} = dout;

    ls_req_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A flushed head must not reach memory, so flush blocks issue.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop     = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (mc.ok_flag_from_mc) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ena_q   <= FALSE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= FLAG_READ;
            size_q  <= '0;
            op_q    <= NOP;
            tag_q   <= '0;
            squash  <= FALSE;
            valid   <= FALSE;
            result  <= '0;
            tag_out <= '0;
        end else begin
            ena_q <= FALSE;
            valid <= FALSE;
            if (pop) begin
                ena_q  <= TRUE;
                addr_q <= head_req.addr;
                data_q <= head_req.data;
                wr_q   <= is_store(head_req.op) ? FLAG_WRITE
                                                : FLAG_READ;
                size_q <= mem_size(head_req.op);
                op_q   <= head_req.op;
                tag_q  <= head_tag;
                squash <= FALSE;
            end else if (state == WAIT) begin
                // A rolled-back load still drains the mc, silently.
                if (mc.ok_flag_from_mc) begin
                    if (!is_store(op_q) && !squash && !flush) begin
                        valid   <= TRUE;
                        result  <= load_ext(op_q, mc.data_from_mc);
                        tag_out <= tag_q;
                    end
                end else if (flush) begin
                    squash <= TRUE;
                end
            end
        end
    end

    assign mc.ena_to_mc     = ena_q;
    assign mc.addr_to_mc    = addr_q;
    assign mc.data_to_mc    = data_q;
    assign mc.wr_flag_to_mc = wr_q;
    assign mc.size_to_mc    = size_q;

endmodule

// File: tb/tb_ls_ex_queue.sv
// Bench for ls_ex_queue: directed scenarios then random traffic,
// checked cycle by cycle against a queue-level reference model.
module tb_ls_ex_queue;
    import ls_ex_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic [3:0]        openum;
    logic [31:0]       mem_addr;
    logic [31:0]       store_value;
    logic [TAG_W-1:0]  tag_in;
    logic              flush;
    logic              ready_to_lsb;
    logic              valid;
    logic [31:0]       result;
    logic [TAG_W-1:0]  tag_out;

    ls_ex_queue_if mc ();

    ls_ex_queue #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .openum       (openum),
        .mem_addr     (mem_addr),
        .store_value  (store_value),
        .tag_in       (tag_in),
        .flush        (flush),
        .ready_to_lsb (ready_to_lsb),
        .mc           (mc),
        .valid        (valid),
        .result       (result),
        .tag_out      (tag_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Memory-controller model
    int          mc_lat   = 3;
    bit          mc_stall = 1'b0;
    logic [31:0] mc_mem [logic [31:0]];
    bit          mc_pend  = 1'b0;
    int          mc_cnt   = 0;
    logic [31:0] mc_a     = '0;

    function automatic logic [31:0] mc_rd(logic [31:0] a);
        if (mc_mem.exists(a)) return mc_mem[a];
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    initial begin
        mc.ok_flag_from_mc = 1'b0;
        mc.data_from_mc    = '0;
        forever begin
            @(negedge clk);
            mc.ok_flag_from_mc = 1'b0;
            if (rst === 1'b1) begin
                mc_pend = 1'b0;
            end else if (mc.ena_to_mc === 1'b1) begin
                mc_pend = 1'b1;
                mc_cnt  = mc_lat;
                mc_a    = mc.addr_to_mc;
            end else if (mc_pend && !mc_stall) begin
                if (mc_cnt <= 1) begin
                    mc.ok_flag_from_mc = 1'b1;
                    mc.data_from_mc    = mc_rd(mc_a);
                    mc_pend            = 1'b0;
                end else begin
                    mc_cnt--;
                end
            end
        end
    end

    // Reference model
    typedef struct {
        logic [3:0]       op;
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } mreq_t;

    mreq_t       mq [$];
    mreq_t       cur;
    bit          busy   = 1'b0;
    bit          squash = 1'b0;

    int          valid_cnt = 0;
    int          issue_cnt = 0;
    logic [31:0] res_log  [$];
    int          tag_log  [$];
    logic [2:0]  size_log [$];
    logic        wr_log   [$];
    logic [31:0] data_log [$];

    function automatic bit ref_load(logic [3:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic [31:0] ref_size(logic [3:0] op);
        case (op)
            LB, LBU, SB: return 32'd1;
            LH, LHU, SH: return 32'd2;
            LW, SW:      return 32'd4;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_ext(logic [3:0] op,
                                            logic [31:0] d);
        case (op)
            LB:      return 32'($signed(d[7:0]));
            LH:      return 32'($signed(d[15:0]));
            LBU:     return d & 32'h0000_00FF;
            LHU:     return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        bit          acc;
        bit          iss = 1'b0;
        bit          ev  = 1'b0;
        logic [31:0] er  = '0;
        logic [31:0] et  = '0;
        if (rst) begin
            mq.delete();
            busy   = 1'b0;
            squash = 1'b0;
        end else begin
            acc = ena && (openum != NOP) && !flush
                  && (mq.size() < DEPTH);
            if (busy && mc.ok_flag_from_mc) begin
                busy = 1'b0;
                if (ref_load(cur.op) && !squash && !flush) begin
                    ev = 1'b1;
                    er = ref_ext(cur.op, mc.data_from_mc);
                    et = 32'(cur.tag);
                end
            end else if (!busy && mq.size() > 0 && !flush) begin
                cur    = mq.pop_front();
                busy   = 1'b1;
                squash = 1'b0;
                iss    = 1'b1;
            end else if (busy && flush) begin
                squash = 1'b1;
            end
            if (flush) mq.delete();
            else if (acc)
                mq.push_back('{openum, mem_addr, store_value, tag_in});
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("ready", 32'(ready_to_lsb), 32'(mq.size() < DEPTH));
        chk("ena_to_mc", 32'(mc.ena_to_mc), 32'(iss));
        chk("valid", 32'(valid), 32'(ev));
        if (ev) begin
            chk("result", result, er);
            chk("tag_out", 32'(tag_out), et);
        end
        if (busy) begin
            chk("mc_addr", mc.addr_to_mc, cur.addr);
            chk("mc_data", mc.data_to_mc, cur.data);
            chk("mc_size", 32'(mc.size_to_mc), ref_size(cur.op));
            chk("mc_wr", 32'(mc.wr_flag_to_mc),
                32'(ref_load(cur.op) ? FLAG_READ : FLAG_WRITE));
        end
        if (valid === 1'b1) begin
            valid_cnt++;
            res_log.push_back(result);
            tag_log.push_back(int'(tag_out));
        end
        if (mc.ena_to_mc === 1'b1) begin
            issue_cnt++;
            size_log.push_back(mc.size_to_mc);
            wr_log.push_back(mc.wr_flag_to_mc);
            data_log.push_back(mc.data_to_mc);
        end
    endtask

    task automatic idle_in();
        ena         = 1'b0;
        openum      = NOP;
        mem_addr    = '0;
        store_value = '0;
        tag_in      = '0;
        flush       = 1'b0;
    endtask

    task automatic req(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] v,
                       input logic [TAG_W-1:0] t);
        ena         = 1'b1;
        openum      = op;
        mem_addr    = a;
        store_value = v;
        tag_in      = t;
        tick();
        idle_in();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_ena"},   32'(mc.ena_to_mc), 32'd0);
        chk({p, "_valid"}, 32'(valid), 32'd0);
        chk({p, "_ready"}, 32'(ready_to_lsb), 32'd1);
        chk({p, "_res"},   result, 32'd0);
        chk({p, "_tag"},   32'(tag_out), 32'd0);
        chk({p, "_addr"},  mc.addr_to_mc, 32'd0);
        chk({p, "_data"},  mc.data_to_mc, 32'd0);
        chk({p, "_wr"},    32'(mc.wr_flag_to_mc), 32'(FLAG_READ));
        chk({p, "_size"},  32'(mc.size_to_mc), 32'd0);
    endtask

    int v0;
    int i0;

    initial begin
        rst = 1'b1;
        idle_in();
        run(2);
        chk_reset("reset");
        rst = 1'b0;
        run(2);

        // LW with three-cycle memory latency
        mc_mem[32'h100] = 32'h1234_5678;
        mc_lat = 3;
        v0 = valid_cnt;
        req(LW, 32'h100, 32'h0, 4'd5);
        chk("lat_n", 32'(mc.ena_to_mc), 32'd0);
        tick();
        chk("lat_n1", 32'(mc.ena_to_mc), 32'd1);
        tick();
        chk("pulse", 32'(mc.ena_to_mc), 32'd0);
        run(10);
        chk("lw_vcnt", 32'(valid_cnt - v0), 32'd1);
        chk("lw_res", res_log[$], 32'h1234_5678);
        chk("lw_tag", 32'(tag_log[$]), 32'd5);

        // Sign / zero extension
        mc_mem[32'h300] = 32'h0000_00F0;
        mc_mem[32'h304] = 32'h0000_00F0;
        mc_mem[32'h308] = 32'h0000_8001;
        res_log.delete();
        size_log.delete();
        req(LB,  32'h300, 32'h0, 4'd1);
        req(LBU, 32'h304, 32'h0, 4'd2);
        req(LH,  32'h308, 32'h0, 4'd3);
        run(30);
        chk("ext_cnt", 32'(res_log.size()), 32'd3);
        chk("lb_res",  res_log[0], 32'hFFFF_FFF0);
        chk("lbu_res", res_log[1], 32'h0000_00F0);
        chk("lh_res",  res_log[2], 32'hFFFF_8001);
        chk("lb_size",  32'(size_log[0]), 32'd1);
        chk("lbu_size", 32'(size_log[1]), 32'd1);
        chk("lh_size",  32'(size_log[2]), 32'd2);

        // Overfill while the controller is stalled
        mc_stall = 1'b1;
        tag_log.delete();
        req(LW, 32'h400, 32'h0, 4'd0);
        tick();
        for (int t = 1; t <= DEPTH + 1; t++) begin
            req(LW, 32'h400 + 32'(4 * t), 32'h0, TAG_W'(t));
            chk("fill_ready", 32'(ready_to_lsb), 32'(t < DEPTH));
        end
        mc_stall = 1'b0;
        run(60);
        chk("fifo_cnt", 32'(tag_log.size()), 32'(DEPTH + 1));
        for (int k = 0; k <= DEPTH; k++)
            chk("fifo_ord", 32'(tag_log[k]), 32'(k));

        // Store
        v0 = valid_cnt;
        wr_log.delete();
        size_log.delete();
        data_log.delete();
        req(SW, 32'h200, 32'hDEAD_BEEF, 4'd9);
        run(10);
        chk("sw_wr",   32'(wr_log[0]), 32'(FLAG_WRITE));
        chk("sw_size", 32'(size_log[0]), 32'd4);
        chk("sw_data", data_log[0], 32'hDEAD_BEEF);
        chk("sw_noval", 32'(valid_cnt - v0), 32'd0);

        // Flush with a load in flight and two queued
        mc_stall = 1'b1;
        v0 = valid_cnt;
        req(LW, 32'h500, 32'h0, 4'd7);
        tick();
        req(LW, 32'h504, 32'h0, 4'd8);
        req(LW, 32'h508, 32'h0, 4'd9);
        i0 = issue_cnt;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", 32'(ready_to_lsb), 32'd1);
        mc_stall = 1'b0;
        run(20);
        chk("flush_noval", 32'(valid_cnt - v0), 32'd0);
        chk("flush_noiss", 32'(issue_cnt - i0), 32'd0);

        // Reset while waiting on the controller
        mc_stall = 1'b1;
        req(LW, 32'h600, 32'h0, 4'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rstwait");
        mc_stall = 1'b0;
        v0 = valid_cnt;
        i0 = issue_cnt;
        run(10);
        chk("rst_noval", 32'(valid_cnt - v0), 32'd0);
        chk("rst_noiss", 32'(issue_cnt - i0), 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            mc_stall    = ($urandom_range(0, 9) == 0);
            mc_lat      = int'($urandom_range(1, 4));
            ena         = ($urandom_range(0, 2) != 0);
            openum      = 4'($urandom_range(0, 8));
            mem_addr    = $urandom;
            store_value = $urandom;
            tag_in      = TAG_W'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            tick();
        end
        idle_in();
        rst      = 1'b0;
        mc_stall = 1'b0;
        run(30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_ex_queue.md
LS_EX_QUEUE -- requirements
Module: ls_ex_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, width of the ROB tag carried with each request.
REQ-003 SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  in  1  request valid from LSB.
REQ-006 SHALL have port openum  in  OPENUM_LEN  operation code (LB/LH/LW/LBU/LHU/SB/SH/SW/NOP).
REQ-007 SHALL have port mem_addr  in  ADDR_LEN  effective address.
REQ-008 SHALL have port store_value  in  DATA_LEN  store data.
REQ-009 SHALL have port tag_in  in  TAG_W  ROB tag of request.
REQ-010 SHALL have port flush  in  1  misprediction rollback.
REQ-011 SHALL have port ready_to_lsb  out  1  queue can accept this cycle.
REQ-012 SHALL have ports ena_to_mc out 1, addr_to_mc out ADDR_LEN, data_to_mc out DATA_LEN, wr_flag_to_mc out 1, size_to_mc out 3, ok_flag_from_mc in 1, data_from_mc in DATA_LEN: memory-controller port.
REQ-013 SHALL have ports valid out 1, result out DATA_LEN, tag_out out TAG_W: CDB broadcast.

Function
REQ-014 SHALL assert ready_to_lsb combinationally when queue count < DEPTH.
REQ-015 SHALL enqueue {openum, mem_addr, store_value, tag_in} when ena=1, openum!=NOP, ready_to_lsb=1, flush=0; otherwise the input is dropped.
REQ-016 SHALL support simultaneous enqueue and dequeue when not full; count unchanged, pointers wrap modulo DEPTH.
REQ-017 SHALL use states IDLE and WAIT; IDLE with non-empty queue pops head, drives mc fields, sets ena_to_mc=1 for exactly one cycle, enters WAIT.
REQ-018 SHALL, in WAIT, hold ena_to_mc=0 and addr/data/wr_flag/size stable until ok_flag_from_mc=1, then return to IDLE.
REQ-019 SHALL give latency: request enqueued at edge N into empty IDLE queue -> ena_to_mc=1 after edge N+1.
REQ-020 SHALL drive size_to_mc = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW; wr_flag_to_mc = FLAG_WRITE for stores, FLAG_READ for loads.
REQ-021 SHALL, on load completion, assert valid for one cycle with tag_out = request tag and result = data_from_mc sign-extended from bit 7 (LB), bit 15 (LH), zero-extended (LBU, LHU), unchanged (LW).
REQ-022 SHALL never assert valid for stores.
REQ-023 SHALL, on flush, empty the queue at that edge (ready_to_lsb=1 next cycle); flush wins over a same-cycle enqueue.
REQ-024 SHALL let an in-flight store complete normally after flush; an in-flight load completes on the mc port but its valid is suppressed.
REQ-025 SHALL allow a new issue in the cycle after return to IDLE (back-to-back issue spacing >=2 cycles beyond mc latency).

Reset
REQ-026 SHALL, on rst, set state IDLE, count 0, pointers 0, squash flag 0, ena_to_mc 0, valid 0, result 0, tag_out 0, addr_to_mc 0, data_to_mc 0, wr_flag_to_mc FLAG_READ, size_to_mc 0.
REQ-027 SHALL, on reset mid-WAIT, abandon the request; the memory controller is reset in the same cycle.

Structure
REQ-028 SHALL take OPENUM codes, FLAG_READ/FLAG_WRITE, ADDR_LEN, DATA_LEN, OPENUM_LEN, TRUE/FALSE from the shared defines file; no local redefinition.
REQ-029 SHALL place the queue in one sub-module ls_req_fifo (parameters DEPTH, entry width; push/pop/clear/full/empty).

Verification
REQ-030 LW addr 0x100, mc returns 0x12345678 after 3 cycles -> ena_to_mc one-cycle pulse, valid=1 one cycle, result 0x12345678, tag_out = tag_in.
REQ-031 LB vs LBU, data_from_mc 0x000000F0 -> result 0xFFFFFFF0 (LB), 0x000000F0 (LBU); LH with 0x8001 -> 0xFFFF8001; size_to_mc 1/1/2.
REQ-032 DEPTH+1 back-to-back requests while mc stalled -> ready_to_lsb=0 after DEPTH accepted, extra dropped, remaining issued in FIFO order.
REQ-033 SW addr 0x200 value 0xDEADBEEF -> wr_flag_to_mc=FLAG_WRITE, size 4, data 0xDEADBEEF, valid never asserted.
REQ-034 Flush with load in WAIT plus 2 queued -> queue empty next cycle, load completion gives valid=0, no further issue.
REQ-035 rst asserted during WAIT -> next cycle ena_to_mc=0, valid=0, ready_to_lsb=1, all REQ-026 values.
